// File: rtl/fwd_select_unit_pkg.sv
// Shared forwarding constants and types for the EX-stage operand muxes.
// The operand muxes decode the same FWD_* codes that this package defines.
package fwd_select_unit_pkg;
  localparam int REG_W = 5;

  typedef logic [1:0]       fwd_sel_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam fwd_sel_t FWD_REG   = 2'b00;  // register file read data
  localparam fwd_sel_t FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam fwd_sel_t FWD_MEMWB = 2'b10;  // MEM/WB writeback data
  localparam fwd_sel_t FWD_IMM   = 2'b11;  // sign-extended immediate (B only)

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/fwd_select_unit_if.sv
// ID-side bus of the forwarding unit.
// master: drives the ID instruction fields and flush, and observes the results.
// slave : the forwarding unit. It reads the ID fields and drives the selects,
//         the stall and the pipeline tracking state (exposed for visibility).
interface fwd_select_unit_if;
  import fwd_select_unit_pkg::*;

  logic     id_valid;
  reg_idx_t id_rs;
  reg_idx_t id_rt;
  logic     id_rt_used;
  logic     id_use_imm;
  reg_idx_t id_dest;
  logic     id_regwrite;
  logic     id_memread;
  logic     flush;

  fwd_sel_t fwd_a_sel;
  fwd_sel_t fwd_b_sel;
  logic     stall;

  reg_idx_t ex_dest;
  logic     ex_regwrite;
  logic     ex_memread;
  reg_idx_t mem_dest;
  logic     mem_regwrite;
  reg_idx_t wb_dest;
  logic     wb_regwrite;

  modport master (
    output id_valid, id_rs, id_rt, id_rt_used, id_use_imm,
           id_dest, id_regwrite, id_memread, flush,
    input  fwd_a_sel, fwd_b_sel, stall,
           ex_dest, ex_regwrite, ex_memread,
           mem_dest, mem_regwrite, wb_dest, wb_regwrite
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rt_used, id_use_imm,
           id_dest, id_regwrite, id_memread, flush,
    output fwd_a_sel, fwd_b_sel, stall,
           ex_dest, ex_regwrite, ex_memread,
           mem_dest, mem_regwrite, wb_dest, wb_regwrite
  );
endinterface

// File: rtl/fwd_select_unit_compare.sv
// fwd_compare: priority comparator for one EX operand.
// Ports: i_src (source register), i_ex_dest/i_ex_regwrite and
//        i_mem_dest/i_mem_regwrite (producers one and two stages ahead),
//        o_sel (2-bit forwarding code, never FWD_IMM).
module fwd_compare
  import fwd_select_unit_pkg::*;
(
  input  reg_idx_t i_src,
  input  reg_idx_t i_ex_dest,
  input  logic     i_ex_regwrite,
  input  reg_idx_t i_mem_dest,
  input  logic     i_mem_regwrite,
  output fwd_sel_t o_sel
);

  // Newest producer wins; $0 is hardwired and never forwarded.
  always_comb begin
    o_sel = FWD_REG;
    if (i_src == REG_ZERO) begin
      o_sel = FWD_REG;
    end else if (i_ex_regwrite && (i_ex_dest == i_src)) begin
      o_sel = FWD_EXMEM;
    end else if (i_mem_regwrite && (i_mem_dest == i_src)) begin
      o_sel = FWD_MEMWB;
    end else begin
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/fwd_select_unit.sv
// fwd_select_unit: computes EX operand mux selects at ID, registers them at the
// ID->EX boundary, and detects load-use hazards (one-cycle stall + bubble).
// Ports: i_clk, i_rst_n (async active-low), bus (slave side of
//        fwd_select_unit_if: ID fields + flush in; selects, stall and the
//        tracking state out).
module fwd_select_unit
  import fwd_select_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  fwd_select_unit_if.slave   bus
);

  reg_idx_t r_ex_dest;
  logic     r_ex_regwrite;
  logic     r_ex_memread;
  reg_idx_t r_mem_dest;
  logic     r_mem_regwrite;
  reg_idx_t r_wb_dest;
  logic     r_wb_regwrite;
  fwd_sel_t r_fwd_a_sel;
  fwd_sel_t r_fwd_b_sel;

  fwd_sel_t w_a_sel;
  fwd_sel_t w_b_sel;
  logic     w_ex_load;
  logic     w_stall;
  logic     w_bubble;

  fwd_compare u_cmp_a (
    .i_src          (bus.id_rs),
    .i_ex_dest      (r_ex_dest),
    .i_ex_regwrite  (r_ex_regwrite),
    .i_mem_dest     (r_mem_dest),
    .i_mem_regwrite (r_mem_regwrite),
    .o_sel          (w_a_sel)
  );

  fwd_compare u_cmp_b (
    .i_src          (bus.id_rt),
    .i_ex_dest      (r_ex_dest),
    .i_ex_regwrite  (r_ex_regwrite),
    .i_mem_dest     (r_mem_dest),
    .i_mem_regwrite (r_mem_regwrite),
    .o_sel          (w_b_sel)
  );

  // Load-use detect; a flush squashes the consumer, so it never stalls.
  always_comb begin
    w_ex_load = r_ex_memread && r_ex_regwrite && (r_ex_dest != REG_ZERO);
    w_stall   = 1'b0;
    if (bus.flush || !bus.id_valid) begin
      w_stall = 1'b0;
    end else if (w_ex_load &&
                 ((r_ex_dest == bus.id_rs) ||
                  (bus.id_rt_used && (r_ex_dest == bus.id_rt)))) begin
      w_stall = 1'b1;
    end else begin
      w_stall = 1'b0;
    end
    w_bubble = bus.flush || !bus.id_valid || w_stall;
  end

  // Pipeline tracking shift and registered selects; bubbles enter EX as nops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_dest      <= REG_ZERO;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_dest     <= REG_ZERO;
      r_mem_regwrite <= 1'b0;
      r_wb_dest      <= REG_ZERO;
      r_wb_regwrite  <= 1'b0;
      r_fwd_a_sel    <= FWD_REG;
      r_fwd_b_sel    <= FWD_REG;
    end else begin
      r_mem_dest     <= r_ex_dest;
      r_mem_regwrite <= r_ex_regwrite;
      r_wb_dest      <= r_mem_dest;
      r_wb_regwrite  <= r_mem_regwrite;
      if (w_bubble) begin
        r_ex_dest     <= REG_ZERO;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_fwd_a_sel   <= FWD_REG;
        r_fwd_b_sel   <= FWD_REG;
      end else begin
        r_ex_dest     <= bus.id_dest;
        r_ex_regwrite <= bus.id_regwrite;
        r_ex_memread  <= bus.id_memread;
        r_fwd_a_sel   <= w_a_sel;
        r_fwd_b_sel   <= bus.id_use_imm ? FWD_IMM : w_b_sel;
      end
    end
  end

  assign bus.fwd_a_sel    = r_fwd_a_sel;
  assign bus.fwd_b_sel    = r_fwd_b_sel;
  assign bus.stall        = w_stall;
  assign bus.ex_dest      = r_ex_dest;
  assign bus.ex_regwrite  = r_ex_regwrite;
  assign bus.ex_memread   = r_ex_memread;
  assign bus.mem_dest     = r_mem_dest;
  assign bus.mem_regwrite = r_mem_regwrite;
  assign bus.wb_dest      = r_wb_dest;
  assign bus.wb_regwrite  = r_wb_regwrite;

endmodule
